maclaurin_result_buffer: RTL and testbench

- Downstream stage of the Maclaurin pipeline datapath. Captures each finished result (Y, overflow, error) when the controller pulses its done strobe.
- Holds results in a small FIFO and presents them to the consumer with a valid/ready handshake.
- Decouples the non-stallable 4-stage pipeline from a consumer that may apply backpressure. Gives the controller an in_ready signal so it can hold off launching new X/N operands.

---
 rtl/maclaurin_pkg.sv | 40 ++++
 rtl/maclaurin_result_buffer_if.sv | 36 +++
 rtl/result_fifo_mem.sv | 26 ++
 rtl/maclaurin_result_buffer.sv | 91 +++++++++
 tb/tb_maclaurin_result_buffer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/maclaurin_pkg.sv
// rtl/maclaurin_pkg.sv - shared types and constants for the Maclaurin result buffer
// Contents: result_t entry layout {y, overflow, error}, RESULT_W, SAT_VALUE,
//           DEFAULT_DEPTH, and gate_result() which forms the stored entry.
// Build option: MACLAURIN_RESULT_SATURATE_EN saturates Y of overflowed results.
package maclaurin_pkg;

  localparam int          RESULT_W      = 34;
  localparam int          DEFAULT_DEPTH = 4;
  localparam logic [31:0] SAT_VALUE     = 32'hFFFF_FFFF;

`ifdef MACLAURIN_RESULT_SATURATE_EN
  localparam bit SAT_ON = 1'b1;
`else
  localparam bit SAT_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] y;
    logic        overflow;
    logic        error;
  } result_t;

  // An input-range error invalidates the datapath output, so Y and overflow
  // are zeroed; otherwise an overflowed Y may be clamped to all-ones.
  function automatic result_t gate_result(input logic [31:0] y,
                                          input logic        overflow,
                                          input logic        error);
    result_t r;
    r.error    = error;
    r.overflow = overflow & ~error;
    if (error)
      r.y = '0;
    else if (SAT_ON && overflow)
      r.y = SAT_VALUE;
    else
      r.y = y;
    return r;
  endfunction

endpackage

// File: rtl/maclaurin_result_buffer_if.sv
// rtl/maclaurin_result_buffer_if.sv - producer/consumer bus of the result buffer
// Signals: in_valid/in_y/in_overflow/in_error/in_ready (controller side),
//          out_valid/out_ready/out_y/out_overflow/out_error (consumer side),
//          count/drop/drop_clr (status).
// Modports: master drives results and consumer ready; slave is the buffer.
interface maclaurin_result_buffer_if #(
  parameter int AW = 2
);

  logic        in_valid;
  logic [31:0] in_y;
  logic        in_overflow;
  logic        in_error;
  logic        in_ready;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic        out_overflow;
  logic        out_error;

  logic [AW:0] count;
  logic        drop;
  logic        drop_clr;

  modport master (
    output in_valid, in_y, in_overflow, in_error, out_ready, drop_clr,
    input  in_ready, out_valid, out_y, out_overflow, out_error, count, drop
  );

  modport slave (
    input  in_valid, in_y, in_overflow, in_error, out_ready, drop_clr,
    output in_ready, out_valid, out_y, out_overflow, out_error, count, drop
  );

endinterface

// File: rtl/result_fifo_mem.sv
// rtl/result_fifo_mem.sv - DEPTH x RESULT_W register array, sync write, async read
// Ports: clk; we/waddr/wdata write port; raddr/rdata combinational read port.
// Storage is deliberately not reset; occupancy tracking lives in the top.
module result_fifo_mem
  import maclaurin_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 2
) (
  input  logic                clk,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [RESULT_W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [RESULT_W-1:0] rdata
);

  logic [RESULT_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/maclaurin_result_buffer.sv
// rtl/maclaurin_result_buffer.sv - result FIFO between Maclaurin pipeline and consumer
// Ports: clk; rst (async, active-low); bus (maclaurin_result_buffer_if.slave)
//        carrying the done-strobe input, valid/ready output, count and drop.
// Build option: MACLAURIN_RESULT_SATURATE_EN (see maclaurin_pkg).
module maclaurin_result_buffer
  import maclaurin_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  maclaurin_result_buffer_if.slave bus
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          drop_q,   drop_d;

  logic    full;
  logic    push;
  logic    pop;
  logic    drop_set;
  result_t wr_entry;
  result_t rd_entry;

  assign full = (count_q == FULL_COUNT);
  assign pop  = (count_q != '0) & bus.out_ready;
  // A full buffer can still take a result when the head leaves this cycle.
  assign push     = bus.in_valid & (~full | pop);
  assign drop_set = bus.in_valid & ~push;
  assign wr_entry = gate_result(bus.in_y, bus.in_overflow, bus.in_error);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    drop_d   = drop_q;

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // A new drop event outranks a clear in the same cycle.
    if (drop_set)          drop_d = 1'b1;
    else if (bus.drop_clr) drop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  result_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign bus.in_ready     = ~full;
  assign bus.out_valid    = (count_q != '0);
  assign bus.out_y        = rd_entry.y;
  assign bus.out_overflow = rd_entry.overflow;
  assign bus.out_error    = rd_entry.error;
  assign bus.count        = count_q;
  assign bus.drop         = drop_q;

endmodule

// File: tb/tb_maclaurin_result_buffer.sv
// tb/tb_maclaurin_result_buffer.sv - self-checking bench for maclaurin_result_buffer
module tb_maclaurin_result_buffer;
  import maclaurin_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

`ifdef MACLAURIN_RESULT_SATURATE_EN
  localparam bit SAT_EXPECT = 1'b1;
`else
  localparam bit SAT_EXPECT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  maclaurin_result_buffer_if #(.AW(AW)) bus();

  maclaurin_result_buffer #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  result_t mq[$];
  bit      m_drop = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic result_t model_entry(input logic [31:0] y, input bit ov, input bit err);
    result_t r;
    if (err) begin
      r.y = 32'h0; r.overflow = 1'b0; r.error = 1'b1;
    end else begin
      r.y = (ov && SAT_EXPECT) ? 32'hFFFF_FFFF : y;
      r.overflow = ov; r.error = 1'b0;
    end
    return r;
  endfunction

  // Reference model: a queue of stored entries plus a sticky drop bit.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete();
      m_drop = 1'b0;
    end else begin
      bit pop_m, push_m;
      pop_m  = (mq.size() != 0) && bus.out_ready;
      push_m = bus.in_valid && ((mq.size() < DEPTH) || pop_m);
      if (pop_m) void'(mq.pop_front());
      if (push_m) mq.push_back(model_entry(bus.in_y, bus.in_overflow, bus.in_error));
      if (bus.in_valid && !push_m) m_drop = 1'b1;
      else if (bus.drop_clr)       m_drop = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("m_out_valid", bus.out_valid, (mq.size() != 0));
      chk("m_count",     bus.count,     mq.size());
      chk("m_in_ready",  bus.in_ready,  (mq.size() < DEPTH));
      chk("m_drop",      bus.drop,      m_drop);
      if (mq.size() != 0) begin
        chk("m_out_y",        bus.out_y,        mq[0].y);
        chk("m_out_overflow", bus.out_overflow, mq[0].overflow);
        chk("m_out_error",    bus.out_error,    mq[0].error);
      end
    end
  end

  task automatic tick(input bit iv, input logic [31:0] y, input bit ov, input bit err,
                      input bit ordy, input bit dclr);
    bus.in_valid    = iv;
    bus.in_y        = y;
    bus.in_overflow = ov;
    bus.in_error    = err;
    bus.out_ready   = ordy;
    bus.drop_clr    = dclr;
    @(posedge clk);
    #2;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.drop_clr  = 1'b0;
  endtask

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_y        = 32'h0;
    bus.in_overflow = 1'b0;
    bus.in_error    = 1'b0;
    bus.out_ready   = 1'b0;
    bus.drop_clr    = 1'b0;

    #3;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count",     bus.count,     0);
    chk("rst_drop",      bus.drop,      0);
    chk("rst_in_ready",  bus.in_ready,  1);
    #9 rst = 1'b1;

    tick(1, 32'h0001_8000, 0, 0, 0, 0);
    chk("t1_out_valid", bus.out_valid, 1);
    chk("t1_out_y",     bus.out_y,     32'h0001_8000);
    chk("t1_count",     bus.count,     1);
    tick(0, 0, 0, 0, 1, 0);
    chk("t1_pop_count", bus.count,     0);
    chk("t1_pop_valid", bus.out_valid, 0);

    for (int i = 0; i < 4; i++) tick(1, 32'h10 + i, 0, 0, 0, 0);
    chk("t2_full_count",    bus.count,    4);
    chk("t2_full_in_ready", bus.in_ready, 0);
    tick(1, 32'h14, 0, 0, 0, 0);
    chk("t2_drop",       bus.drop,  1);
    chk("t2_drop_count", bus.count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_y", bus.out_y, 32'h10 + i);
      tick(0, 0, 0, 0, 1, 0);
    end
    chk("t2_drop_kept", bus.drop, 1);
    tick(0, 0, 0, 0, 0, 1);
    chk("t2_drop_clr", bus.drop, 0);

    for (int i = 0; i < 4; i++) tick(1, 32'h20 + i, 0, 0, 0, 0);
    tick(1, 32'hAA, 0, 0, 1, 0);
    chk("t3_count", bus.count, 4);
    chk("t3_drop",  bus.drop,  0);
    for (int i = 0; i < 4; i++) begin
      chk("t3_drain_y", bus.out_y, (i == 3) ? 32'hAA : 32'h21 + i);
      tick(0, 0, 0, 0, 1, 0);
    end

    tick(1, 32'h1234, 0, 1, 0, 0);
    chk("t4_y",   bus.out_y,        32'h0);
    chk("t4_ov",  bus.out_overflow, 0);
    chk("t4_err", bus.out_error,    1);
    tick(0, 0, 0, 0, 1, 0);

    tick(1, 32'h0000_00FF, 1, 0, 0, 0);
    chk("t5_y",  bus.out_y, SAT_EXPECT ? 32'hFFFF_FFFF : 32'h0000_00FF);
    chk("t5_ov", bus.out_overflow, 1);
    tick(0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 5; i++) tick(1, 32'h30 + i, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 1, 0);
    chk("t6_pre_count", bus.count, 3);
    chk("t6_pre_drop",  bus.drop,  1);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_valid", bus.out_valid, 0);
    chk("t6_rst_count", bus.count,     0);
    chk("t6_rst_drop",  bus.drop,      0);
    #2 rst = 1'b1;
    tick(1, 32'h55, 0, 0, 0, 0);
    chk("t6_first_y",   bus.out_y, 32'h55);
    chk("t6_first_cnt", bus.count, 1);
    tick(0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(0, 9) < 6), $urandom, ($urandom_range(0, 9) < 3),
           ($urandom_range(0, 9) < 2), ($urandom_range(0, 9) < 5),
           ($urandom_range(0, 9) < 1));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
